// File: rtl/sdma_share_arb.sv
// Round-robin arbiter that lets NUM_CLIENTS IPs share one SDMA channel, with a
// grant timeout and Wishbone-mapped control, status, interrupt and count registers.
module sdma_share_arb #(
    parameter int NUM_CLIENTS = 4,
    parameter int TIMEOUT_W   = 12,
    parameter int TIMEOUT_MAX = 4095,
    parameter int ADDRWIDTH   = 3
) (
    input  logic                   WB_CLK,
    input  logic                   WB_RST,
    input  logic [ADDRWIDTH-1:0]   WBs_ADR,
    input  logic                   WBs_CYC,
    input  logic                   WBs_STB,
    input  logic                   WBs_WE,
    input  logic [3:0]             WBs_BYTE_STB,
    input  logic [31:0]            WBs_WR_DAT,
    output logic [31:0]            WBs_RD_DAT,
    output logic                   WBs_ACK,
    input  logic [NUM_CLIENTS-1:0] ch_req_i,
    input  logic [NUM_CLIENTS-1:0] ch_sreq_i,
    output logic [NUM_CLIENTS-1:0] ch_active_o,
    output logic [NUM_CLIENTS-1:0] ch_done_o,
    output logic                   SDMA_Req_o,
    output logic                   SDMA_Sreq_o,
    input  logic                   SDMA_Active_i,
    input  logic                   SDMA_Done_i,
    output logic                   intr_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [2:0]           LAST_IDX = 3'(NUM_CLIENTS - 1);
    localparam logic [TIMEOUT_W-1:0] TO_LAST  = TIMEOUT_W'(TIMEOUT_MAX - 1);
    localparam logic [ADDRWIDTH-1:0] A_CTRL   = ADDRWIDTH'(0);
    localparam logic [ADDRWIDTH-1:0] A_STATUS = ADDRWIDTH'(1);
    localparam logic [ADDRWIDTH-1:0] A_ISTAT  = ADDRWIDTH'(2);
    localparam logic [ADDRWIDTH-1:0] A_IEN    = ADDRWIDTH'(3);
    localparam logic [ADDRWIDTH-1:0] A_XFER   = ADDRWIDTH'(4);

    state_t                 state_q, state_d;
    logic [2:0]             grant_q, grant_d;
    logic                   mode_q, mode_d;
    logic [2:0]             rr_q, rr_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic                   req_q, req_d;
    logic                   sreq_q, sreq_d;
    logic [NUM_CLIENTS-1:0] done_q, done_d;
    logic [NUM_CLIENTS-1:0] ctrl_q, ctrl_d;
    logic [NUM_CLIENTS-1:0] int_done_q, int_done_d;
    logic                   int_to_q, int_to_d;
    logic [NUM_CLIENTS-1:0] ien_done_q, ien_done_d;
    logic                   ien_to_q, ien_to_d;
    logic [15:0]            xfer_cnt_q, xfer_cnt_d;
    logic                   ack_q, ack_d;
    logic [31:0]            rd_dat_q, rd_dat_d;
    logic                   intr_q, intr_d;

    logic [7:0]             elig8, req8;
    logic [2:0]             cand, pick_idx;
    logic                   pick_found;
    logic [NUM_CLIENTS-1:0] grant_oh;
    logic [2:0]             grant_next;
    logic [NUM_CLIENTS-1:0] hw_done_set;
    logic                   hw_to_set;
    logic                   xfer_inc;

    logic                   wb_sel, wb_wr, wb_rd;
    logic [31:0]            wr_mask, wdat_m, rd_val;
    logic                   unused_bits;

    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            grant_oh[i] = (grant_q == 3'(i));
        end
    end

    assign grant_next = (grant_q == LAST_IDX) ? 3'd0 : grant_q + 3'd1;

    // Search starts at the RR pointer and wraps, so the first hit is the fair winner.
    always_comb begin
        elig8 = '0;
        req8  = '0;
        elig8[NUM_CLIENTS-1:0] = ctrl_q & (ch_req_i | ch_sreq_i);
        req8[NUM_CLIENTS-1:0]  = ch_req_i;
        cand       = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            cand = 3'((int'(rr_q) + k) % NUM_CLIENTS);
            if (!pick_found && elig8[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mode_d      = mode_q;
        rr_d        = rr_q;
        timer_d     = timer_q;
        req_d       = 1'b0;
        sreq_d      = 1'b0;
        done_d      = '0;
        hw_done_set = '0;
        hw_to_set   = 1'b0;
        xfer_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (pick_found) begin
                    grant_d = pick_idx;
                    mode_d  = ~req8[pick_idx];
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // The timer only runs while the request is visible to the SDMA.
                if (SDMA_Active_i) begin
                    state_d = ST_ACTIVE;
                end else if ((req_q || sreq_q) && (timer_q == TO_LAST)) begin
                    hw_to_set = 1'b1;
                    rr_d      = grant_next;
                    state_d   = ST_IDLE;
                end else begin
                    req_d  = ~mode_q;
                    sreq_d = mode_q;
                    if (req_q || sreq_q) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (SDMA_Done_i) begin
                    done_d      = grant_oh;
                    hw_done_set = grant_oh;
                    xfer_inc    = 1'b1;
                    rr_d        = grant_next;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wb_sel  = WBs_CYC & WBs_STB & ~ack_q;
    assign wb_wr   = wb_sel & WBs_WE;
    assign wb_rd   = wb_sel & ~WBs_WE;
    assign wr_mask = {{8{WBs_BYTE_STB[3]}}, {8{WBs_BYTE_STB[2]}},
                      {8{WBs_BYTE_STB[1]}}, {8{WBs_BYTE_STB[0]}}};
    assign wdat_m  = WBs_WR_DAT & wr_mask;
    assign unused_bits = ^{wdat_m, wr_mask};

    always_comb begin
        ack_d      = wb_sel;
        ctrl_d     = ctrl_q;
        ien_done_d = ien_done_q;
        ien_to_d   = ien_to_q;
        int_done_d = int_done_q | hw_done_set;
        int_to_d   = int_to_q | hw_to_set;
        xfer_cnt_d = xfer_cnt_q + {15'd0, xfer_inc};
        if (wb_wr) begin
            case (WBs_ADR)
                A_CTRL: ctrl_d = (ctrl_q & ~wr_mask[NUM_CLIENTS-1:0]) | wdat_m[NUM_CLIENTS-1:0];
                A_ISTAT: begin
                    // A hardware set in the same cycle survives the clear.
                    int_done_d = (int_done_q & ~wdat_m[NUM_CLIENTS-1:0]) | hw_done_set;
                    int_to_d   = (int_to_q & ~wdat_m[16]) | hw_to_set;
                end
                A_IEN: begin
                    ien_done_d = (ien_done_q & ~wr_mask[NUM_CLIENTS-1:0]) | wdat_m[NUM_CLIENTS-1:0];
                    ien_to_d   = wr_mask[16] ? wdat_m[16] : ien_to_q;
                end
                A_XFER:  xfer_cnt_d = {15'd0, xfer_inc};
                default: ;
            endcase
        end
        rd_val = '0;
        case (WBs_ADR)
            A_CTRL:   rd_val[NUM_CLIENTS-1:0] = ctrl_q;
            A_STATUS: begin
                rd_val[1:0] = state_q;
                rd_val[6:4] = grant_q;
                rd_val[8]   = mode_q;
            end
            A_ISTAT: begin
                rd_val[NUM_CLIENTS-1:0] = int_done_q;
                rd_val[16]              = int_to_q;
            end
            A_IEN: begin
                rd_val[NUM_CLIENTS-1:0] = ien_done_q;
                rd_val[16]              = ien_to_q;
            end
            A_XFER:   rd_val[15:0] = xfer_cnt_q;
            default:  rd_val = '0;
        endcase
        rd_dat_d = wb_rd ? rd_val : 32'd0;
        intr_d   = (|(int_done_q & ien_done_q)) | (int_to_q & ien_to_q);
    end

    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            mode_q     <= 1'b0;
            rr_q       <= '0;
            timer_q    <= '0;
            req_q      <= 1'b0;
            sreq_q     <= 1'b0;
            done_q     <= '0;
            ctrl_q     <= '0;
            int_done_q <= '0;
            int_to_q   <= 1'b0;
            ien_done_q <= '0;
            ien_to_q   <= 1'b0;
            xfer_cnt_q <= '0;
            ack_q      <= 1'b0;
            rd_dat_q   <= '0;
            intr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            mode_q     <= mode_d;
            rr_q       <= rr_d;
            timer_q    <= timer_d;
            req_q      <= req_d;
            sreq_q     <= sreq_d;
            done_q     <= done_d;
            ctrl_q     <= ctrl_d;
            int_done_q <= int_done_d;
            int_to_q   <= int_to_d;
            ien_done_q <= ien_done_d;
            ien_to_q   <= ien_to_d;
            xfer_cnt_q <= xfer_cnt_d;
            ack_q      <= ack_d;
            rd_dat_q   <= rd_dat_d;
            intr_q     <= intr_d;
        end
    end

    assign SDMA_Req_o  = req_q;
    assign SDMA_Sreq_o = sreq_q;
    assign ch_active_o = ((state_q == ST_ACTIVE) && SDMA_Active_i) ? grant_oh : '0;
    assign ch_done_o   = done_q;
    assign WBs_ACK     = ack_q;
    assign WBs_RD_DAT  = rd_dat_q;
    assign intr_o      = intr_q;

endmodule

// File: tb/tb_sdma_share_arb.sv
// Directed bench for sdma_share_arb: arbitration order, handshake timing,
// timeout, interrupt W1C collision and asynchronous reset behaviour.
module tb_sdma_share_arb;
    localparam int NC = 4;
    localparam int TM = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  adr;
    logic        cyc, stb, we;
    logic [3:0]  be;
    logic [31:0] wdat, rdat;
    logic        ack;
    logic [NC-1:0] ch_req, ch_sreq, ch_active, ch_done;
    logic        sdma_req, sdma_sreq, sdma_active, sdma_done, intr;

    int checks   = 0;
    int failures = 0;

    sdma_share_arb #(.NUM_CLIENTS(NC), .TIMEOUT_W(12), .TIMEOUT_MAX(TM), .ADDRWIDTH(3)) dut (
        .WB_CLK(clk), .WB_RST(rst), .WBs_ADR(adr), .WBs_CYC(cyc), .WBs_STB(stb),
        .WBs_WE(we), .WBs_BYTE_STB(be), .WBs_WR_DAT(wdat), .WBs_RD_DAT(rdat),
        .WBs_ACK(ack), .ch_req_i(ch_req), .ch_sreq_i(ch_sreq), .ch_active_o(ch_active),
        .ch_done_o(ch_done), .SDMA_Req_o(sdma_req), .SDMA_Sreq_o(sdma_sreq),
        .SDMA_Active_i(sdma_active), .SDMA_Done_i(sdma_done), .intr_o(intr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        int n;
        adr = a; wdat = d; be = b; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        step();
        n = 1;
        while (!ack && n < 4) begin
            step();
            n++;
        end
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL wb_write_ack adr=%0d got=%b exp=1", a, ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [2:0] a, output logic [31:0] d);
        int n;
        adr = a; we = 1'b0; be = 4'hF; cyc = 1'b1; stb = 1'b1;
        step();
        n = 1;
        while (!ack && n < 4) begin
            step();
            n++;
        end
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL wb_read_ack adr=%0d got=%b exp=1", a, ack);
        end
        d = rdat;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (!(sdma_req || sdma_sreq) && n < 30) begin
            step();
            n++;
        end
        ok = sdma_req || sdma_sreq;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        ch_req = '0; ch_sreq = '0; sdma_active = 1'b0; sdma_done = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; be = '0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        apply_reset();
        checks++;
        if ({sdma_req, sdma_sreq, ch_active, ch_done, intr, ack} !== '0 || rdat !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs req=%b sreq=%b act=%b done=%b intr=%b ack=%b rd=%h exp all 0",
                     sdma_req, sdma_sreq, ch_active, ch_done, intr, ack, rdat);
        end
        wb_read(3'd1, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
        wb_read(3'd0, d);
        checks++;
        if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    endtask

    task automatic test_basic_transfer();
        logic [31:0] d;
        wb_write(3'd0, 32'hF, 4'hF);
        ch_req = 4'b0001;
        step();
        checks++;
        if (sdma_req !== 1'b0) begin failures++; $display("FAIL basic_req_early got=%b exp=0", sdma_req); end
        step();
        checks++;
        if (sdma_req !== 1'b1) begin failures++; $display("FAIL basic_req_rise got=%b exp=1", sdma_req); end
        repeat (3) step();
        sdma_active = 1'b1;
        step();
        checks++;
        if (ch_active !== 4'b0001 || sdma_req !== 1'b0) begin
            failures++;
            $display("FAIL basic_active act=%b req=%b exp act=0001 req=0", ch_active, sdma_req);
        end
        ch_req = '0;
        wb_read(3'd1, d);
        checks++;
        if (d !== 32'h002) begin failures++; $display("FAIL basic_status_active got=%h exp=002", d); end
        repeat (7) step();
        sdma_done = 1'b1;
        step();
        sdma_done = 1'b0;
        sdma_active = 1'b0;
        checks++;
        if (ch_done !== 4'b0001) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0001", ch_done); end
        step();
        checks++;
        if (ch_done !== 4'b0000) begin failures++; $display("FAIL basic_done_width got=%b exp=0000", ch_done); end
        wb_read(3'd2, d);
        checks++;
        if (d !== 32'h1) begin failures++; $display("FAIL basic_int_stat got=%h exp=1", d); end
        sdma_done = 1'b1;
        step();
        sdma_done = 1'b0;
        wb_read(3'd4, d);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL basic_xfer_cnt got=%0d exp=1", d); end
        checks++;
        if (intr !== 1'b0) begin failures++; $display("FAIL basic_intr_masked got=%b exp=0", intr); end
    endtask

    task automatic test_round_robin();
        logic [31:0] d;
        logic [NC-1:0] exp_oh;
        bit ok;
        apply_reset();
        wb_write(3'd0, 32'hF, 4'hF);
        ch_req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            exp_oh = 4'(1 << (i % 4));
            wait_req(ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL rr_req_timeout xfer=%0d got=0 exp=1", i); end
            sdma_active = 1'b1;
            step();
            checks++;
            if (ch_active !== exp_oh) begin
                failures++;
                $display("FAIL rr_grant_order xfer=%0d got=%b exp=%b", i, ch_active, exp_oh);
            end
            sdma_done = 1'b1;
            step();
            sdma_done = 1'b0;
            sdma_active = 1'b0;
            checks++;
            if (ch_done !== exp_oh) begin
                failures++;
                $display("FAIL rr_done xfer=%0d got=%b exp=%b", i, ch_done, exp_oh);
            end
        end
        ch_req = '0;
        wb_read(3'd4, d);
        checks++;
        if (d !== 32'd8) begin failures++; $display("FAIL rr_xfer_cnt got=%0d exp=8", d); end
    endtask

    task automatic serve_one();
        sdma_active = 1'b1;
        step();
        sdma_done = 1'b1;
        step();
        sdma_done = 1'b0;
        sdma_active = 1'b0;
    endtask

    task automatic test_single_mode();
        logic [31:0] d;
        bit ok;
        apply_reset();
        wb_write(3'd0, 32'hF, 4'hF);
        ch_sreq = 4'b0100;
        wait_req(ok);
        checks++;
        if (!ok || sdma_sreq !== 1'b1 || sdma_req !== 1'b0) begin
            failures++;
            $display("FAIL single_outputs sreq=%b req=%b exp sreq=1 req=0", sdma_sreq, sdma_req);
        end
        wb_read(3'd1, d);
        checks++;
        if (d !== 32'h121) begin failures++; $display("FAIL single_status got=%h exp=121", d); end
        ch_sreq = '0;
        serve_one();
        ch_req = 4'b0010;
        ch_sreq = 4'b0010;
        wait_req(ok);
        checks++;
        if (!ok || sdma_req !== 1'b1 || sdma_sreq !== 1'b0) begin
            failures++;
            $display("FAIL both_burst_wins req=%b sreq=%b exp req=1 sreq=0", sdma_req, sdma_sreq);
        end
        wb_read(3'd1, d);
        checks++;
        if (d !== 32'h011) begin failures++; $display("FAIL both_status got=%h exp=011", d); end
        ch_req = '0;
        ch_sreq = '0;
        serve_one();
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        bit ok;
        int cnt;
        apply_reset();
        wb_write(3'd0, 32'hF, 4'hF);
        wb_write(3'd3, 32'h10000, 4'hF);
        ch_req = 4'b0011;
        wait_req(ok);
        cnt = 0;
        while (sdma_req && cnt < 40) begin
            cnt++;
            step();
        end
        checks++;
        if (!ok || cnt != TM) begin failures++; $display("FAIL timeout_req_cycles got=%0d exp=%0d", cnt, TM); end
        wb_read(3'd2, d);
        checks++;
        if (d !== 32'h10000) begin failures++; $display("FAIL timeout_int_stat got=%h exp=10000", d); end
        checks++;
        if (intr !== 1'b1) begin failures++; $display("FAIL timeout_intr got=%b exp=1", intr); end
        wb_read(3'd1, d);
        checks++;
        if (d !== 32'h011) begin failures++; $display("FAIL timeout_next_grant got=%h exp=011", d); end
        ch_req = '0;
        sdma_active = 1'b1;
        step();
        checks++;
        if (ch_active !== 4'b0010) begin failures++; $display("FAIL timeout_next_active got=%b exp=0010", ch_active); end
        sdma_done = 1'b1;
        step();
        sdma_done = 1'b0;
        sdma_active = 1'b0;
    endtask

    task automatic test_w1c_collision();
        logic [31:0] d;
        bit ok;
        apply_reset();
        wb_write(3'd0, 32'h1, 4'hF);
        wb_write(3'd3, 32'h1, 4'hF);
        ch_req = 4'b0001;
        wait_req(ok);
        sdma_active = 1'b1;
        step();
        ch_req = '0;
        step();
        adr = 3'd2; wdat = 32'h1; be = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        sdma_done = 1'b1;
        step();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sdma_done = 1'b0;
        sdma_active = 1'b0;
        wb_read(3'd2, d);
        checks++;
        if (!ok || d !== 32'h1) begin failures++; $display("FAIL w1c_hw_wins got=%h exp=1", d); end
        checks++;
        if (intr !== 1'b1) begin failures++; $display("FAIL w1c_intr_set got=%b exp=1", intr); end
        wb_write(3'd2, 32'h1, 4'hF);
        checks++;
        if (intr !== 1'b1) begin failures++; $display("FAIL w1c_intr_latency got=%b exp=1", intr); end
        step();
        checks++;
        if (intr !== 1'b0) begin failures++; $display("FAIL w1c_intr_fall got=%b exp=0", intr); end
        wb_read(3'd2, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL w1c_cleared got=%h exp=0", d); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d;
        bit ok;
        apply_reset();
        wb_write(3'd0, 32'hF, 4'hF);
        ch_req = 4'b0001;
        wait_req(ok);
        ch_req = '0;
        serve_one();
        ch_req = 4'b0010;
        wait_req(ok);
        sdma_active = 1'b1;
        step();
        ch_req = '0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (!ok || sdma_req !== 1'b0 || ch_active !== 4'b0000) begin
            failures++;
            $display("FAIL rst_active_async req=%b act=%b exp req=0 act=0000", sdma_req, ch_active);
        end
        sdma_active = 1'b0;
        step();
        rst = 1'b0;
        step();
        wb_read(3'd1, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rst_status got=%h exp=0", d); end
        wb_read(3'd0, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rst_ctrl got=%h exp=0", d); end
        wb_read(3'd4, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rst_xfer_cnt got=%0d exp=0", d); end
        wb_write(3'd0, 32'hF, 4'hF);
        ch_req = 4'b0001;
        wait_req(ok);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (!ok || sdma_req !== 1'b0) begin failures++; $display("FAIL rst_grant_async req=%b exp=0", sdma_req); end
        ch_req = '0;
        step();
        rst = 1'b0;
        step();
        wb_write(3'd0, 32'hFF, 4'b0010);
        wb_read(3'd0, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL byte_mask_ctrl got=%h exp=0", d); end
        wb_write(3'd0, 32'hFF, 4'b0001);
        wb_read(3'd0, d);
        checks++;
        if (d !== 32'hF) begin failures++; $display("FAIL lane0_ctrl got=%h exp=F", d); end
        wb_read(3'd5, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", d); end
    endtask

    initial begin
        rst = 1'b1;
        ch_req = '0; ch_sreq = '0; sdma_active = 1'b0; sdma_done = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; be = '0;
        test_reset();
        test_basic_transfer();
        test_round_robin();
        test_single_mode();
        test_timeout();
        test_w1c_collision();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim_time=%0t limit=500000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
